// File: rtl/mux_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mux_arb_pkg (package)
//  Purpose : Shared types and helpers for the round-robin mux arbiter.
//            - arb_state_t : output stage state (EMPTY / FULL)
//            - rr_pick     : behavioural round-robin winner search, usable by
//                            any block that needs a reference pick
//  Revision: 1.0 - initial release
// ============================================================================
package mux_arb_pkg;

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } arb_state_t;

   localparam int MAX_INPUTS = 16;

   // First set bit of req searching ptr+1, ptr+2, ... modulo n.
   // Returns 0 when nothing is requested.
   function automatic logic [3:0] rr_pick(input logic [MAX_INPUTS-1:0] req,
                                          input logic [3:0]            ptr,
                                          input int unsigned           n);
      logic [3:0]  pick;
      logic        found;
      int unsigned idx;
      pick  = 4'd0;
      found = 1'b0;
      idx   = 0;
      for (int unsigned k = 1; k <= MAX_INPUTS; k++) begin
         if (n != 0 && k <= n) begin
            idx = (32'(ptr) + k) % n;
            if (!found && req[idx[3:0]]) begin
               found = 1'b1;
               pick  = idx[3:0];
            end
         end
      end
      return pick;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mux_rr_arbiter_pick.sv
`default_nettype none
// ============================================================================
//  Module  : rr_pick_onehot
//  Purpose : Combinational round-robin pick. The request vector is rotated so
//            that bit 0 is requester ptr+1, priority-encoded (lowest wins),
//            and the offset is added back to ptr to recover the index.
//  Ports   : req    in  NUM_INPUTS  request vector
//            ptr    in  SEL_W       last granted index
//            grant  out NUM_INPUTS  one-hot of winner, zero if no request
//            winner out SEL_W       winner index (valid when found=1)
//            found  out 1           any request present
//  Revision: 1.0 - initial release
// ============================================================================
module rr_pick_onehot
   import mux_arb_pkg::*;
#(
   parameter  int NUM_INPUTS = 4,
   localparam int SEL_W      = $clog2(NUM_INPUTS)
) (
   input  logic [NUM_INPUTS-1:0] req,
   input  logic [SEL_W-1:0]      ptr,
   output logic [NUM_INPUTS-1:0] grant,
   output logic [SEL_W-1:0]      winner,
   output logic                  found
);

   logic [NUM_INPUTS-1:0] rot;
   logic [SEL_W-1:0]      offset;

   // NUM_INPUTS is a power of two, so SEL_W-bit arithmetic wraps modulo N.
   always_comb begin
      rot = '0;
      for (int j = 0; j < NUM_INPUTS; j++) begin
         rot[j] = req[SEL_W'(ptr + SEL_W'(j + 1))];
      end
   end

   // Scan high to low so the lowest set bit is the last one written.
   always_comb begin
      found  = 1'b0;
      offset = '0;
      for (int j = NUM_INPUTS - 1; j >= 0; j--) begin
         if (rot[j]) begin
            found  = 1'b1;
            offset = SEL_W'(j);
         end
      end
   end

   assign winner = ptr + offset + SEL_W'(1);
   assign grant  = found ? (NUM_INPUTS'(1) << winner) : '0;

endmodule
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : mux_rr_arbiter
//  Purpose : Round-robin arbiter sharing one WIDTH-bit N:1 data mux among
//            NUM_INPUTS valid/ready requesters, with a registered output
//            stage carrying its own valid/ready handshake.
//  Ports   : clk, rst_n            clock, asynchronous active-low reset
//            req_valid/req_ready   per-requester handshake (ready one-hot/0)
//            req_data[NUM_INPUTS]  requester words
//            req_lock              (MUX_ARB_LOCK_EN only) hold grant on winner
//            out_valid/out_ready   output handshake
//            out_data, out_sel     captured word and its requester index
//            busy                  output stage FULL
//  Config  : `define MUX_ARB_LOCK_EN adds the req_lock port and lock state.
//  Revision: 1.0 - initial release
// ============================================================================
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter  int WIDTH      = 8,
   parameter  int NUM_INPUTS = 4,
   localparam int SEL_W      = $clog2(NUM_INPUTS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_INPUTS-1:0] req_valid,
   input  logic [WIDTH-1:0]      req_data [NUM_INPUTS],
`ifdef MUX_ARB_LOCK_EN
   input  logic [NUM_INPUTS-1:0] req_lock,
`endif
   output logic [NUM_INPUTS-1:0] req_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [SEL_W-1:0]      out_sel,
   output logic                  busy
);

   arb_state_t            state;
   arb_state_t            state_next;
   logic [SEL_W-1:0]      ptr;

   logic [NUM_INPUTS-1:0] rr_grant;
   logic [SEL_W-1:0]      rr_winner;
   logic                  rr_found;

   logic                  eligible;
   logic                  cap;
   logic [SEL_W-1:0]      winner;
   logic [NUM_INPUTS-1:0] grant;

   rr_pick_onehot #(
      .NUM_INPUTS (NUM_INPUTS)
   ) u_pick (
      .req    (req_valid),
      .ptr    (ptr),
      .grant  (rr_grant),
      .winner (rr_winner),
      .found  (rr_found)
   );

   // A word accepted while rst_n is low would be lost, so no ready is
   // offered until reset is released.
   assign eligible = rst_n & ((state == EMPTY) | out_ready);

`ifdef MUX_ARB_LOCK_EN
   logic             locked;
   logic [SEL_W-1:0] locked_id;
   logic             lock_hold;

   // Lock only holds while its owner keeps requesting; otherwise normal RR
   // resumes from ptr, which still equals locked_id.
   assign lock_hold = locked & req_valid[locked_id];

   always_comb begin
      winner = rr_winner;
      grant  = rr_grant;
      if (lock_hold) begin
         winner = locked_id;
         grant  = NUM_INPUTS'(1) << locked_id;
      end
   end

   assign cap = eligible & (lock_hold | rr_found);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         locked    <= 1'b0;
         locked_id <= '0;
      end else if (cap) begin
         locked    <= req_lock[winner];
         locked_id <= winner;
      end else if (eligible) begin
         // eligible without cap means nothing is requesting at all
         locked    <= 1'b0;
      end
   end
`else
   assign winner = rr_winner;
   assign grant  = rr_grant;
   assign cap    = eligible & rr_found;
`endif

   assign req_ready = grant & {NUM_INPUTS{cap}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      out_valid  = 1'b0;
      busy       = 1'b0;
      case (state)
         EMPTY: begin
            if (cap) begin
               state_next = FULL;
            end
         end
         FULL: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            if (out_ready && !cap) begin
               state_next = EMPTY;
            end
         end
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data <= '0;
         out_sel  <= '0;
         ptr      <= SEL_W'(NUM_INPUTS - 1);
      end else if (cap) begin
         out_data <= req_data[winner];
         out_sel  <= winner;
         ptr      <= winner;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mux_rr_arbiter
//  Purpose : Self-checking bench for mux_rr_arbiter (WIDTH=8, NUM_INPUTS=4).
//            Vector table, hand-written multi-cycle sequences and a random
//            run against a behavioural round-robin model.
//  Config  : honours MUX_ARB_LOCK_EN for the lock sequence.
//  Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mux_rr_arbiter;

   localparam int WIDTH = 8;
   localparam int N     = 4;
   localparam int SW    = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [N-1:0]     req_valid = '0;
   logic [WIDTH-1:0] req_data [N];
   logic [N-1:0]     req_ready;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_data;
   logic [SW-1:0]    out_sel;
   logic             busy;
`ifdef MUX_ARB_LOCK_EN
   logic [N-1:0]     req_lock = '0;
`endif

   mux_rr_arbiter #(.WIDTH(WIDTH), .NUM_INPUTS(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
`ifdef MUX_ARB_LOCK_EN
      .req_lock  (req_lock),
`endif
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int cmp_count  = 0;
   int fail_count = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_count++;
      if (act !== exp) begin
         fail_count++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit         m_valid;
   logic [7:0] m_data;
   int         m_sel;
   int         m_ptr;

   function automatic int model_winner(input logic [N-1:0] v, input int p);
      for (int k = 1; k <= N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_sel   = 0;
      m_ptr   = N - 1;
   endtask

   task automatic cycle_checked(input string tag);
      int           w;
      bit           take;
      logic [N-1:0] r;
      @(negedge clk);
      w    = model_winner(req_valid, m_ptr);
      take = (w >= 0) && (!m_valid || out_ready);
      r    = take ? (N'(1) << w) : '0;
      chk({tag, " req_ready"}, 32'(req_ready), 32'(r));
      @(posedge clk);
      if (take) begin
         m_valid = 1'b1;
         m_data  = req_data[w];
         m_sel   = w;
         m_ptr   = w;
      end else if (out_ready) begin
         m_valid = 1'b0;
      end
      #1;
      chk({tag, " out_valid"}, 32'(out_valid), 32'(m_valid));
      chk({tag, " busy"},      32'(busy),      32'(m_valid));
      chk({tag, " out_data"},  32'(out_data),  32'(m_data));
      chk({tag, " out_sel"},   32'(out_sel),   32'(m_sel));
   endtask

   task automatic set_fixed_data();
      req_data[0] = 8'h3a;
      req_data[1] = 8'h6b;
      req_data[2] = 8'hf3;
      req_data[3] = 8'h45;
   endtask

   // Hold reset two cycles with every requester valid, then release.
   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '1;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset out_data",  32'(out_data),  32'd0);
      chk("reset req_ready", 32'(req_ready), 32'd0);
      chk("reset busy",      32'(busy),      32'd0);
      @(negedge clk);
      req_valid = '0;
      rst_n     = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [3:0] valid;
      logic       ready;
      logic [3:0] exp_rdy;
      logic       exp_ov;
      logic [1:0] exp_sel;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs [15];

   initial begin
      int exp_lock [5];

      vecs[0]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hf3};
      vecs[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 8'hf3};
      vecs[2]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h3a};
      vecs[3]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hf3};
      vecs[4]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h3a};
      vecs[5]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h3a};
      vecs[6]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h3a};
      vecs[7]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h6b};
      vecs[8]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hf3};
      vecs[9]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h45};
      vecs[10] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h3a};
      vecs[11] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h45};
      vecs[12] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h45};
      vecs[13] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd3, 8'h45};
      vecs[14] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 8'h45};

      set_fixed_data();
      do_reset();

      for (int i = 0; i < 15; i++) begin
         req_valid = vecs[i].valid;
         out_ready = vecs[i].ready;
         @(negedge clk);
         chk($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'(vecs[i].exp_rdy));
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
         chk($sformatf("vec%0d busy", i),      32'(busy),      32'(vecs[i].exp_ov));
         chk($sformatf("vec%0d out_sel", i),   32'(out_sel),   32'(vecs[i].exp_sel));
         chk($sformatf("vec%0d out_data", i),  32'(out_data),  32'(vecs[i].exp_data));
      end

      // ---- 8 back-to-back captures, then backpressure ----
      do_reset();
      req_valid = 4'b1111;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cycle_checked("rr8");
         chk($sformatf("rr8 seq%0d", i), 32'(out_sel), 32'(i % N));
         chk($sformatf("rr8 nobubble%0d", i), 32'(out_valid), 32'd1);
      end
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle_checked("bp");
         chk("bp hold sel",  32'(out_sel),  32'd3);
         chk("bp hold data", 32'(out_data), 32'h45);
      end
      out_ready = 1'b1;
      cycle_checked("bp release");
      chk("bp release sel", 32'(out_sel), 32'd0);

      // ---- asynchronous reset while FULL and stalled ----
      out_ready = 1'b0;
      cycle_checked("pre async");
      #2;
      rst_n = 1'b0;
      #1;
      chk("async out_valid", 32'(out_valid), 32'd0);
      chk("async out_data",  32'(out_data),  32'd0);
      chk("async busy",      32'(busy),      32'd0);
      @(negedge clk);
      req_valid = '0;
      rst_n     = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
      req_valid = 4'b1111;
      out_ready = 1'b1;
      cycle_checked("post async");
      chk("post async sel", 32'(out_sel), 32'd0);

`ifdef MUX_ARB_LOCK_EN
      // ---- lock on requester 1 for three words ----
      do_reset();
      exp_lock  = '{0, 1, 1, 1, 2};
      req_valid = 4'b1111;
      out_ready = 1'b1;
      req_lock  = 4'b0010;
      for (int i = 0; i < 5; i++) begin
         if (i == 3) req_lock = 4'b0000;
         @(negedge clk);
         chk($sformatf("lock%0d req_ready", i), 32'(req_ready), 32'(N'(1) << exp_lock[i]));
         @(posedge clk);
         #1;
         chk($sformatf("lock%0d out_sel", i), 32'(out_sel), 32'(exp_lock[i]));
      end
      req_lock = '0;
`else
      exp_lock = '{0, 0, 0, 0, 0};
`endif

      // ---- randomized run against the model ----
      do_reset();
      for (int i = 0; i < 400; i++) begin
         req_valid = N'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 9) < 7);
         for (int k = 0; k < N; k++) req_data[k] = WIDTH'($urandom);
         cycle_checked("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
      $finish;
   end

endmodule
`default_nettype wire
